// File: rtl/lc3b_mem_responder_pkg.sv
// Shared LC-3b memory-side types: data word, byte mask and responder state.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        mem_idle,
        mem_busy,
        mem_resp_st
    } lc3b_mem_state;

endpackage

// File: rtl/lc3b_mem_responder_if.sv
// LC-3b memory handshake bundle: CPU side is the master, memory model the slave.
interface lc3b_mem_responder_if;
    import lc3b_types::*;

    logic          mem_read;
    logic          mem_write;
    lc3b_mem_wmask mem_wmask;
    lc3b_word      mem_address;
    lc3b_word      mem_wdata;
    logic          mem_resp;
    lc3b_word      mem_rdata;
    logic          protocol_err;

    modport master (
        output mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
        input  mem_resp, mem_rdata, protocol_err
    );

    modport slave (
        input  mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
        output mem_resp, mem_rdata, protocol_err
    );

endinterface

// File: rtl/lc3b_mem_responder_array.sv
// Word-organised storage with a combinational read port and a byte-enabled
// synchronous write port. Contents are deliberately left unreset.
module lc3b_mem_array
    import lc3b_types::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] idx_i,
    input  lc3b_mem_wmask        wmask_i,
    input  lc3b_word             wdata_i,
    output lc3b_word             rdata_o
);

    lc3b_word storage_q [2**ADDR_BITS];

    // Byte-lane write, each lane gated by its mask bit.
    always_ff @(posedge clk) begin
        if (we_i) begin
            if (wmask_i[0]) storage_q[idx_i][7:0]  <= wdata_i[7:0];
            if (wmask_i[1]) storage_q[idx_i][15:8] <= wdata_i[15:8];
        end
    end

    assign rdata_o = storage_q[idx_i];

endmodule

// File: rtl/lc3b_mem_responder.sv
// LC-3b memory responder: accepts one request at a time, answers after
// LATENCY cycles and flags initiator protocol violations (sticky).
//
//   state       | meaning
//   mem_idle    | waiting for exactly one of read/write
//   mem_busy    | request latched, latency counter running down
//   mem_resp_st | one-cycle mem_resp; write commits at the closing edge
module lc3b_mem_responder
    import lc3b_types::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    lc3b_mem_responder_if.slave  mem
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    lc3b_mem_state        state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 op_write_q, op_write_d;
    logic [ADDR_BITS-1:0] idx_q, idx_d;
    lc3b_word             wdata_q, wdata_d;
    lc3b_mem_wmask        wmask_q, wmask_d;
    logic                 err_q, err_d;
    logic                 array_we;
    lc3b_word             array_rdata;
    logic                 unused_addr;

    // Upper address bits alias and bit0 selects a byte within the word.
    assign unused_addr = ^{mem.mem_address[15:ADDR_BITS+1], mem.mem_address[0]};

    // State and latched request registers; reset discards any in-flight request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= mem_idle;
            cnt_q      <= '0;
            op_write_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_write_q <= op_write_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            err_q      <= err_d;
        end
    end

    // Next-state, request capture and violation detection.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_write_d = op_write_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        err_d      = err_q;
        case (state_q)
            mem_idle: begin
                if (mem.mem_read && mem.mem_write) begin
                    err_d = 1'b1;
                end else if (mem.mem_read || mem.mem_write) begin
                    op_write_d = mem.mem_write;
                    idx_d      = mem.mem_address[ADDR_BITS:1];
                    wdata_d    = mem.mem_wdata;
                    wmask_d    = mem.mem_wmask;
                    cnt_d      = CNT_LOAD;
                    state_d    = (LATENCY == 1) ? mem_resp_st : mem_busy;
                end
            end
            mem_busy: begin
                // Dropping the request before mem_resp is an abort.
                if (!mem.mem_read && !mem.mem_write) begin
                    err_d   = 1'b1;
                    state_d = mem_idle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = mem_resp_st;
                end
            end
            mem_resp_st: state_d = mem_idle;
            default:     state_d = mem_idle;
        endcase
    end

    assign array_we         = (state_q == mem_resp_st) && op_write_q;
    assign mem.mem_resp     = (state_q == mem_resp_st);
    assign mem.mem_rdata    = ((state_q == mem_resp_st) && !op_write_q) ? array_rdata : '0;
    assign mem.protocol_err = err_q;

    lc3b_mem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk     (clk),
        .we_i    (array_we),
        .idx_i   (idx_q),
        .wmask_i (wmask_q),
        .wdata_i (wdata_q),
        .rdata_o (array_rdata)
    );

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Directed bench: a LATENCY=4 responder (dut4) and a LATENCY=1 responder (dut1).
module tb_lc3b_mem_responder;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    lc3b_mem_responder_if if4 ();
    lc3b_mem_responder_if if1 ();

    lc3b_mem_responder #(.ADDR_BITS(8), .LATENCY(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .mem   (if4)
    );

    lc3b_mem_responder #(.ADDR_BITS(8), .LATENCY(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .mem   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_req(input int sel, input logic rd, input logic wr,
                           input logic [15:0] addr, input logic [15:0] wd,
                           input logic [1:0] wm);
        if (sel == 1) begin
            if1.mem_read = rd; if1.mem_write = wr; if1.mem_address = addr;
            if1.mem_wdata = wd; if1.mem_wmask = wm;
        end else begin
            if4.mem_read = rd; if4.mem_write = wr; if4.mem_address = addr;
            if4.mem_wdata = wd; if4.mem_wmask = wm;
        end
    endtask

    function automatic logic get_resp(input int sel);
        return (sel == 1) ? if1.mem_resp : if4.mem_resp;
    endfunction

    function automatic logic [15:0] get_rdata(input int sel);
        return (sel == 1) ? if1.mem_rdata : if4.mem_rdata;
    endfunction

    // One request; resp_k = negedge index (1 = first after acceptance) of the
    // mem_resp pulse, 0 if none within the budget. stray counts nonzero rdata
    // or resp outside the response cycle.
    task automatic txn(input int sel, input logic wr, input logic [15:0] addr,
                       input logic [15:0] wd, input logic [1:0] wm,
                       output int resp_k, output logic [15:0] rdata, output int stray);
        bit done;
        done   = 1'b0;
        resp_k = 0;
        rdata  = '0;
        stray  = 0;
        @(negedge clk);
        set_req(sel, !wr, wr, addr, wd, wm);
        for (int k = 1; k <= 20; k++) begin
            if (!done) begin
                @(negedge clk);
                if (get_resp(sel)) begin
                    resp_k = k;
                    rdata  = get_rdata(sel);
                    done   = 1'b1;
                    set_req(sel, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
                end else if (get_rdata(sel) !== 16'h0) begin
                    stray++;
                end
            end
        end
        if (done) begin
            @(negedge clk);
            if (get_resp(sel) || get_rdata(sel) !== 16'h0) stray++;
        end else begin
            set_req(sel, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_chk++; if (if4.mem_resp !== 1'b0) begin n_err++; $display("FAIL reset_resp4: got %b expected 0", if4.mem_resp); end
        n_chk++; if (if4.mem_rdata !== 16'h0) begin n_err++; $display("FAIL reset_rdata4: got %h expected 0000", if4.mem_rdata); end
        n_chk++; if (if4.protocol_err !== 1'b0) begin n_err++; $display("FAIL reset_err4: got %b expected 0", if4.protocol_err); end
        n_chk++; if (if1.mem_resp !== 1'b0 || if1.protocol_err !== 1'b0) begin
            n_err++; $display("FAIL reset_dut1: got resp=%b err=%b expected 0 0", if1.mem_resp, if1.protocol_err);
        end
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        int k; logic [15:0] rd; int s; int pulses;
        txn(0, 1'b1, 16'h0010, 16'h1111, 2'b11, k, rd, s);
        n_chk++; if (k !== 4) begin n_err++; $display("FAIL prewrite_latency: got %0d expected 4", k); end
        @(negedge clk);
        set_req(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11);
        repeat (2) @(negedge clk);
        n_chk++; if (if4.mem_resp !== 1'b0) begin n_err++; $display("FAIL busy_noresp: got %b expected 0", if4.mem_resp); end
        reset = 1'b1;
        set_req(0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        #1;
        n_chk++; if (if4.mem_resp !== 1'b0) begin n_err++; $display("FAIL async_reset_resp: got %b expected 0", if4.mem_resp); end
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (if4.mem_resp) pulses++;
        end
        n_chk++; if (pulses !== 0) begin n_err++; $display("FAIL aborted_resp_count: got %0d expected 0", pulses); end
        n_chk++; if (if4.protocol_err !== 1'b0) begin n_err++; $display("FAIL reset_abort_err: got %b expected 0", if4.protocol_err); end
        txn(0, 1'b0, 16'h0010, 16'h0, 2'b00, k, rd, s);
        n_chk++; if (rd !== 16'h1111) begin n_err++; $display("FAIL reset_no_commit: got %h expected 1111", rd); end
    endtask

    task automatic test_read_latency();
        int k; logic [15:0] rd; int s;
        txn(0, 1'b1, 16'h0020, 16'h1234, 2'b11, k, rd, s);
        n_chk++; if (k !== 4) begin n_err++; $display("FAIL write_latency: got %0d expected 4", k); end
        n_chk++; if (rd !== 16'h0) begin n_err++; $display("FAIL write_rdata_zero: got %h expected 0000", rd); end
        txn(0, 1'b0, 16'h0020, 16'h0, 2'b00, k, rd, s);
        n_chk++; if (k !== 4) begin n_err++; $display("FAIL read_latency: got %0d expected 4", k); end
        n_chk++; if (rd !== 16'h1234) begin n_err++; $display("FAIL read_data: got %h expected 1234", rd); end
        n_chk++; if (s !== 0) begin n_err++; $display("FAIL read_rdata_outside: got %0d stray expected 0", s); end
    endtask

    task automatic test_byte_mask();
        int k; logic [15:0] rd; int s;
        txn(0, 1'b1, 16'h0040, 16'hAAAA, 2'b11, k, rd, s);
        txn(0, 1'b1, 16'h0040, 16'h5500, 2'b10, k, rd, s);
        txn(0, 1'b0, 16'h0040, 16'h0, 2'b00, k, rd, s);
        n_chk++; if (rd !== 16'h55AA) begin n_err++; $display("FAIL mask_hi: got %h expected 55aa", rd); end
        txn(0, 1'b1, 16'h0040, 16'hFFFF, 2'b00, k, rd, s);
        n_chk++; if (k !== 4) begin n_err++; $display("FAIL mask00_resp: got %0d expected 4", k); end
        txn(0, 1'b0, 16'h0040, 16'h0, 2'b00, k, rd, s);
        n_chk++; if (rd !== 16'h55AA) begin n_err++; $display("FAIL mask00_nochange: got %h expected 55aa", rd); end
        txn(0, 1'b1, 16'h0040, 16'h33CC, 2'b01, k, rd, s);
        txn(0, 1'b0, 16'h0040, 16'h0, 2'b00, k, rd, s);
        n_chk++; if (rd !== 16'h55CC) begin n_err++; $display("FAIL mask_lo: got %h expected 55cc", rd); end
    endtask

    task automatic test_wrap();
        int k; logic [15:0] rd; int s;
        txn(0, 1'b1, 16'h0002, 16'h7777, 2'b11, k, rd, s);
        txn(0, 1'b0, 16'h0202, 16'h0, 2'b00, k, rd, s);
        n_chk++; if (rd !== 16'h7777) begin n_err++; $display("FAIL wrap_alias: got %h expected 7777", rd); end
        txn(0, 1'b0, 16'h0003, 16'h0, 2'b00, k, rd, s);
        n_chk++; if (rd !== 16'h7777) begin n_err++; $display("FAIL bit0_ignored: got %h expected 7777", rd); end
        txn(0, 1'b0, 16'h0004, 16'h0, 2'b00, k, rd, s);
        n_chk++; if (rd === 16'h7777) begin n_err++; $display("FAIL neighbour_word: got %h expected not 7777", rd); end
    endtask

    task automatic test_protocol();
        int k; logic [15:0] rd; int s; int pulses;
        // Abort from a clean error flag.
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 16'h0020, 16'h0, 2'b00);
        repeat (2) @(negedge clk);
        set_req(0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (if4.mem_resp) pulses++;
        end
        n_chk++; if (pulses !== 0) begin n_err++; $display("FAIL abort_noresp: got %0d pulses expected 0", pulses); end
        n_chk++; if (if4.protocol_err !== 1'b1) begin n_err++; $display("FAIL abort_err: got %b expected 1", if4.protocol_err); end
        txn(0, 1'b0, 16'h0020, 16'h0, 2'b00, k, rd, s);
        n_chk++; if (k !== 4 || rd !== 16'h1234) begin
            n_err++; $display("FAIL after_abort_read: got k=%0d data=%h expected k=4 data=1234", k, rd);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_chk++; if (if4.protocol_err !== 1'b0) begin n_err++; $display("FAIL err_cleared: got %b expected 0", if4.protocol_err); end
        // Both requests high in IDLE.
        set_req(0, 1'b1, 1'b1, 16'h0020, 16'hDEAD, 2'b11);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (if4.mem_resp) pulses++;
        end
        set_req(0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        n_chk++; if (pulses !== 0) begin n_err++; $display("FAIL both_noresp: got %0d pulses expected 0", pulses); end
        n_chk++; if (if4.protocol_err !== 1'b1) begin n_err++; $display("FAIL both_err: got %b expected 1", if4.protocol_err); end
        txn(0, 1'b0, 16'h0020, 16'h0, 2'b00, k, rd, s);
        n_chk++; if (rd !== 16'h1234) begin n_err++; $display("FAIL both_nowrite: got %h expected 1234", rd); end
        n_chk++; if (if4.protocol_err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b expected 1", if4.protocol_err); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_chk++; if (if4.protocol_err !== 1'b0) begin n_err++; $display("FAIL err_reset: got %b expected 0", if4.protocol_err); end
    endtask

    task automatic test_back_to_back();
        int k; logic [15:0] rd; int s;
        txn(1, 1'b1, 16'h0010, 16'h0101, 2'b11, k, rd, s);
        n_chk++; if (k !== 1) begin n_err++; $display("FAIL lat1_write: got %0d expected 1", k); end
        txn(1, 1'b1, 16'h0012, 16'h0202, 2'b11, k, rd, s);
        @(negedge clk);
        set_req(1, 1'b1, 1'b0, 16'h0010, 16'h0, 2'b00);
        @(negedge clk);
        n_chk++; if (if1.mem_resp !== 1'b1 || if1.mem_rdata !== 16'h0101) begin
            n_err++; $display("FAIL b2b_first: got resp=%b data=%h expected 1 0101", if1.mem_resp, if1.mem_rdata);
        end
        set_req(1, 1'b1, 1'b0, 16'h0012, 16'h0, 2'b00);
        @(negedge clk);
        n_chk++; if (if1.mem_resp !== 1'b0 || if1.mem_rdata !== 16'h0) begin
            n_err++; $display("FAIL b2b_gap: got resp=%b data=%h expected 0 0000", if1.mem_resp, if1.mem_rdata);
        end
        @(negedge clk);
        n_chk++; if (if1.mem_resp !== 1'b1 || if1.mem_rdata !== 16'h0202) begin
            n_err++; $display("FAIL b2b_second: got resp=%b data=%h expected 1 0202", if1.mem_resp, if1.mem_rdata);
        end
        set_req(1, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        @(negedge clk);
        n_chk++; if (if1.mem_resp !== 1'b0) begin n_err++; $display("FAIL b2b_end: got %b expected 0", if1.mem_resp); end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b1;
        set_req(0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        set_req(1, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        test_reset();
        test_reset_mid_busy();
        test_read_latency();
        test_byte_mask();
        test_wrap();
        test_protocol();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/lc3b_mem_responder.md
Name: lc3b_mem_responder

Overview:
- Memory-side responder for the LC-3b CPU memory handshake (mem_read/mem_write/mem_wmask/mem_address/mem_wdata in; mem_resp/mem_rdata out).
- Backs a word-organised, byte-writable storage array.
- Returns each request after a programmable latency; stands in for main memory in datapath/control simulation.
- Also flags protocol violations by the initiator.

Parameters:
- ADDR_BITS, 8, storage holds 2**ADDR_BITS 16-bit words; index = mem_address[ADDR_BITS:1].
- LATENCY, 4, cycles from request acceptance to the mem_resp cycle inclusive; legal range 1..15.

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- mem_read  in  1  read request, held by the initiator until mem_resp
- mem_write  in  1  write request, held by the initiator until mem_resp
- mem_wmask  in  2  byte enables: bit0 = byte [7:0], bit1 = byte [15:8]
- mem_address  in  16  byte address; bit0 ignored
- mem_wdata  in  16  write data
- mem_resp  out  1  one-cycle completion pulse
- mem_rdata  out  16  read data, valid only while mem_resp=1 for a read; 0 otherwise
- protocol_err  out  1  sticky violation flag, cleared only by reset

Behaviour:
- Reset (async, immediate) values:
  - state=IDLE, mem_resp=0, mem_rdata=0, protocol_err=0.
  - Any in-flight transaction is discarded; a pending write does not commit.
  - Storage contents are not reset.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Exactly one of mem_read/mem_write high: latch op, index, wdata, wmask; load counter=LATENCY-1.
  - Go to BUSY, or straight to RESP if LATENCY=1.
  - Both high: no acceptance, protocol_err<=1, stay IDLE.
  - Neither high: stay IDLE.
- BUSY:
  - Decrement counter each cycle; at counter==1 go to RESP.
  - Request inputs sampled here only for abort/consistency:
    - Both mem_read and mem_write low: abort, go IDLE, no mem_resp, no write, protocol_err<=1.
    - Address/wdata/wmask changes after acceptance are ignored (latched values used).
- RESP:
  - mem_resp=1 for exactly this cycle.
  - Read: mem_rdata = storage[latched index], driven combinationally from the latched index.
  - Write: storage updated at the rising edge ending RESP, only the bytes enabled by the latched wmask.
  - wmask=00: completes with mem_resp, no storage change.
  - Always go to IDLE next.
- Latency:
  - Request first seen high at edge T (sampled in IDLE) → mem_resp high in the cycle after edge T+LATENCY-1.
  - LATENCY=1 gives mem_resp in the cycle immediately after acceptance.
- Back-to-back:
  - Initiator deasserts or changes its request in the cycle after mem_resp.
  - The next request is sampled in IDLE; minimum spacing between mem_resp pulses is LATENCY+1 cycles.
- Write-then-read to the same word returns the new data (write committed before IDLE).
- Address wrap: upper address bits above ADDR_BITS are ignored, so aliasing is modulo storage size.
- Request held through RESP into IDLE is treated as a new request. This is legal, since the initiator FSM is expected to move on.

Decomposition:
- Add to package lc3b_types:
  - typedef enum {mem_idle, mem_busy, mem_resp_st} lc3b_mem_state.
- Reuse lc3b_word and lc3b_mem_wmask from the same package.
- Sub-module lc3b_mem_array:
  - 2**ADDR_BITS x 16 storage, combinational read port, synchronous byte-enabled write port.
  - The responder FSM/counter instantiates it.

Test Plan:
- Reset mid-BUSY of a write (LATENCY=4, addr 0x0010, wdata 0xBEEF, wmask 11), then read 0x0010 → old contents returned, no mem_resp during the aborted transaction, protocol_err=0.
- Write 0x1234 to 0x0020 (wmask 11), then read 0x0020 with LATENCY=4 → mem_resp exactly 4 cycles after read acceptance, mem_rdata=0x1234, mem_rdata=0 on the surrounding cycles.
- Write 0xAAAA (wmask 11), then 0x5500 with wmask 10 to 0x0040, read → 0x55AA; wmask 00 write of 0xFFFF → read still 0x55AA, mem_resp still pulses.
- mem_read and mem_write both high in IDLE → no mem_resp, protocol_err=1 and stays 1 until reset; deassert both mid-BUSY → return to IDLE, no mem_resp.
- ADDR_BITS=8: write 0x7777 to 0x0002, read 0x0202 and 0x0003 → both return 0x7777 (wrap, bit0 ignored); LATENCY=1 back-to-back reads → mem_resp pulses 2 cycles apart.
